logicgate_checker: RTL
======================

# logicgate_checker

Synthesizable stimulus-and-response checker for the two-input, eight-output `logicgate` block. It drives the logic gate's `a` and `b` inputs through all four input combinations, samples `y1`..`y8` after a programmable settle time, and compares each output against the golden gate function. It then reports pass/fail, a saturating mismatch count, and the first failing vector and bit mask. It sits beside a `logicgate` instance as its on-chip driver and monitor.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 2: cycles between driving a vector and sampling it; legal range ≥1.
- `ERR_W`, default 6: width of `err_count`; 6 holds the maximum of 32 mismatched bits.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  run request; sampled only in IDLE.
- `y1`..`y8`  input  1 each  outputs of the logic gate block under check.
- `a`, `b`  output  1 each  stimulus to the logic gate block.
- `busy`  output  1  high from the start-accept edge until DONE is exited.
- `done`  output  1  one-cycle pulse when a run completes.
- `pass`  output  1  1 when the last completed run had zero mismatches.
- `err_count`  output  ERR_W  total mismatched output bits over the run; saturates at all-ones.
- `first_fail_vec`  output  2  `{a,b}` of the first failing vector.
- `first_fail_mask`  output  8  XOR of actual and expected at the first failing vector; bit i-1 corresponds to `y<i>`.

## Operation
- Golden function, with `e[7:0]` = expected `{y8..y1}`:
  - y1 = a&b
  - y2 = a|b
  - y3 = ~(a&b)
  - y4 = ~(a|b)
  - y5 = a^b
  - y6 = ~(a^b)
  - y7 = ~a
  - y8 = ~b
- Vector order is 00, 01, 10, 11, with `a` = vec[1] and `b` = vec[0].
- States:
  - IDLE → SETTLE on `start`: vec←0, `{a,b}`←00, clear `err_count`, `first_fail_*` and `pass`, settle counter←0.
  - SETTLE: the counter increments each cycle. After SETTLE_CYCLES cycles, go to CHECK.
  - CHECK (one cycle): compute mism = actual ^ e and add popcount(mism) to `err_count`, saturating.
    - If mism≠0 and no earlier failure in this run, capture `first_fail_vec` and `first_fail_mask`.
    - If vec==3, go to DONE. Otherwise vec++, drive the new `{a,b}`, and go to SETTLE.
  - DONE (one cycle): `done`=1, `pass`←(`err_count`==0), then go to IDLE.
- `start` in any state other than IDLE is ignored. `start` held high in IDLE immediately after DONE begins a new run.
- Results (`pass`, `err_count`, `first_fail_*`) hold their values until the next accepted `start`.
- Reset mid-run aborts the run. No `done` is produced, and all outputs return to their reset values.

## Timing
- Reset values: `a`=0, `b`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `first_fail_vec`=0, `first_fail_mask`=0, state=IDLE.
- All outputs are registered.
- `{a,b}` change only on the start-accept edge and on the CHECK→SETTLE edges.
- Each vector is held for exactly SETTLE_CYCLES+1 cycles, and `y*` are sampled on the final one (CHECK).
- `done` rises 4·(SETTLE_CYCLES+1) clocks after the start-accept edge; with the default of 2, that is 12 clocks. `busy` falls on the same edge that `done` falls.
- `err_count` saturation: an addition that would exceed 2^ERR_W−1 yields 2^ERR_W−1.
- First-failure capture is single-shot per run; later failures never overwrite it.

## Structure
- Shared package `logicgate_pkg` contains:
  - the state enum (IDLE, SETTLE, CHECK, DONE);
  - the constant NUM_VEC=4;
  - the function `lg_expected(a,b)` returning the 8-bit `e`, also used by benches.
- One sub-module, `logicgate_ref`: purely combinational golden model, `{a,b}` → `e[7:0]`, instantiated once inside `logicgate_checker`.
- A popcount and saturating adder live inline in the top module.

## Test plan
- Connect to a correct `logicgate`, SETTLE_CYCLES=2, pulse `start` → `{a,b}` sequence 00,01,10,11, each held 3 cycles; `done` 12 clocks after accept; `pass`=1, `err_count`=0.
- DUT model with y5 stuck at 0 → `err_count`=2, `first_fail_vec`=01, `first_fail_mask`=8'b0001_0000, `pass`=0.
- DUT model with all outputs inverted, ERR_W=4 → `err_count` saturates at 15 (raw total 32), `first_fail_vec`=00, `first_fail_mask`=8'hFF.
- `start` re-pulsed during SETTLE of vector 2 → ignored; single `done` at the original time; results unchanged by the extra pulse.
- `rst_n` asserted during CHECK of vector 1 → immediately `a`=`b`=0, `busy`=0, `err_count`=0, no `done`; a subsequent `start` gives a full clean run with `pass`=1.
- `start` held high continuously → back-to-back runs; second run begins on the edge after `done`; `err_count` cleared at the second accept.

Source files
------------

// File: rtl/logicgate_pkg.sv
// Shared types and golden gate function for the logicgate checker and its benches.
package logicgate_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int NUM_VEC = 4;

  // Returns expected {y8..y1} for the given inputs.
  function automatic logic [7:0] lg_expected(input logic a, input logic b);
    return {~b, ~a, ~(a ^ b), a ^ b, ~(a | b), ~(a & b), a | b, a & b};
  endfunction

endpackage

// File: rtl/logicgate_checker_ref.sv
// Purely combinational golden model of the logicgate block: {a,b} -> expected {y8..y1}.
module logicgate_ref
  import logicgate_pkg::*;
(
  input  logic       a,
  input  logic       b,
  output logic [7:0] e
);

  assign e = lg_expected(a, b);

endmodule

// File: rtl/logicgate_checker.sv
// Drives the logicgate block through all four input vectors, samples its eight outputs after
// a settle delay and reports pass/fail, a saturating mismatch count and the first failure.
module logicgate_checker
  import logicgate_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             y1,
  input  logic             y2,
  input  logic             y3,
  input  logic             y4,
  input  logic             y5,
  input  logic             y6,
  input  logic             y7,
  input  logic             y8,
  output logic             a,
  output logic             b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       first_fail_vec,
  output logic [7:0]       first_fail_mask
);

  localparam int               CNT_W   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [1:0]         vec, vec_next;
  logic               failed, failed_next;
  logic [ERR_W-1:0]   err_next;
  logic [1:0]         ffv_next;
  logic [7:0]         ffm_next;
  logic               pass_next, done_next, busy_next;

  logic [7:0]         expected, actual, mism;
  logic [3:0]         mism_cnt;
  logic [31:0]        err_sum;
  logic [ERR_W-1:0]   err_sat;

  // The stimulus outputs come straight from the vector register, so they are registered too.
  assign a = vec[1];
  assign b = vec[0];

  logicgate_ref u_ref (
    .a (vec[1]),
    .b (vec[0]),
    .e (expected)
  );

  assign actual = {y8, y7, y6, y5, y4, y3, y2, y1};
  assign mism   = actual ^ expected;

  always_comb begin
    mism_cnt = '0;
    for (int i = 0; i < 8; i++) mism_cnt += 4'(mism[i]);
  end

  // Sum in a wide domain so narrow ERR_W values still clamp correctly.
  assign err_sum = 32'(err_count) + 32'(mism_cnt);
  assign err_sat = (err_sum > 32'(ERR_MAX)) ? ERR_MAX : ERR_W'(err_sum);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_next  = state;
    cnt_next    = cnt;
    vec_next    = vec;
    failed_next = failed;
    err_next    = err_count;
    ffv_next    = first_fail_vec;
    ffm_next    = first_fail_mask;
    pass_next   = pass;
    done_next   = 1'b0;
    busy_next   = busy;

    case (state)
      IDLE: begin
        if (start) begin
          state_next  = SETTLE;
          cnt_next    = '0;
          vec_next    = 2'd0;
          failed_next = 1'b0;
          err_next    = '0;
          ffv_next    = 2'd0;
          ffm_next    = 8'd0;
          pass_next   = 1'b0;
          busy_next   = 1'b1;
        end
      end

      SETTLE: begin
        if (cnt == CNT_W'(SETTLE_CYCLES - 1)) state_next = CHECK;
        else                                  cnt_next   = cnt + CNT_W'(1);
      end

      CHECK: begin
        err_next = err_sat;
        if (mism != 8'd0 && !failed) begin
          failed_next = 1'b1;
          ffv_next    = vec;
          ffm_next    = mism;
        end
        if (vec == 2'(NUM_VEC - 1)) begin
          state_next = DONE;
          done_next  = 1'b1;
          pass_next  = (err_sat == '0);
        end else begin
          state_next = SETTLE;
          vec_next   = vec + 2'd1;
          cnt_next   = '0;
        end
      end

      DONE: begin
        state_next = IDLE;
        pass_next  = (err_count == '0);
        busy_next  = 1'b0;
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      cnt             <= '0;
      vec             <= 2'd0;
      failed          <= 1'b0;
      err_count       <= '0;
      first_fail_vec  <= 2'd0;
      first_fail_mask <= 8'd0;
      pass            <= 1'b0;
      done            <= 1'b0;
      busy            <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values together.
      state           <= state_next;
      cnt             <= cnt_next;
      vec             <= vec_next;
      failed          <= failed_next;
      err_count       <= err_next;
      first_fail_vec  <= ffv_next;
      first_fail_mask <= ffm_next;
      pass            <= pass_next;
      done            <= done_next;
      busy            <= busy_next;
    end
  end

endmodule
